// File: rtl/hc595_chain_drv.sv
// Serial driver for a daisy-chain of 74HC595 shift registers.
// It takes a parallel word through a one-entry pending buffer, shifts it out on ds/shcp, then pulses stcp to latch it.
module hc595_chain_drv #(
  parameter int CHAIN_NUM = 2,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*CHAIN_NUM-1:0] din,
  input  logic                   din_vld,
  output logic                   din_rdy,
  output logic                   busy,
  output logic                   done,
  output logic                   shcp,
  output logic                   stcp,
  output logic                   ds,
  output logic                   oe_n
);

  localparam int DATA_W = 8 * CHAIN_NUM;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   pend_buf;
  logic                pend_full;
  logic                div_end;
  logic                bit_last;
  logic                accept;
  logic                load;

  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BIT_W'(DATA_W - 1));
  assign accept   = din_vld && din_rdy;
  assign load     = (state == IDLE) && pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_full) state_nxt = SHIFT;
      SHIFT:   if (div_end && shcp && bit_last) state_nxt = LATCH;
      LATCH:   if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_rdy = !pend_full;
    busy    = (state != IDLE) || pend_full;
    done    = (state == LATCH) && div_end;
  end

  // The pending buffer can be filled in any state; it is drained only by the IDLE load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_buf  <= '0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_buf  <= din;
    end else if (load) begin
      pend_full <= 1'b0;
    end
  end

  // ds is set up at the start of each bit so the shcp rise lands mid-bit; it holds the last bit once the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
      ds      <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (pend_full) begin
            shreg   <= pend_buf;
            bit_cnt <= '0;
            ds      <= MSB_FIRST ? pend_buf[DATA_W-1] : pend_buf[0];
          end
        end
        SHIFT: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          if (div_end) begin
            if (!shcp) begin
              shcp <= 1'b1;
            end else begin
              shcp    <= 1'b0;
              shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
              if (bit_last) stcp <= 1'b1;
              else          ds   <= MSB_FIRST ? shreg[DATA_W-2] : shreg[1];
            end
          end
        end
        LATCH: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          if (div_end) begin
            stcp <= 1'b0;
            oe_n <= 1'b0;
          end
        end
        default: div_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_chain_drv.sv
// Bench for hc595_chain_drv: two instances (16-bit MSB-first /2, 24-bit LSB-first /5) feeding a 595 chain model.
// Accepted words go into a per-instance queue; a monitor pops one at every done pulse and checks the latched frame.
module tb_hc595_chain_drv;

  localparam int DW0 = 16;
  localparam int CD0 = 2;
  localparam int DW1 = 24;
  localparam int CD1 = 5;
  localparam int SPACING0 = DW0 * 2 * CD0 + CD0 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW0-1:0] din0 = '0;
  logic           din_vld0 = 1'b0;
  logic           din_rdy0, busy0, done0, shcp0, stcp0, ds0, oe_n0;
  logic [DW1-1:0] din1 = '0;
  logic           din_vld1 = 1'b0;
  logic           din_rdy1, busy1, done1, shcp1, stcp1, ds1, oe_n1;

  hc595_chain_drv #(.CHAIN_NUM(2), .CLK_DIV(CD0), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_vld(din_vld0), .din_rdy(din_rdy0),
    .busy(busy0), .done(done0), .shcp(shcp0), .stcp(stcp0), .ds(ds0), .oe_n(oe_n0));

  hc595_chain_drv #(.CHAIN_NUM(3), .CLK_DIV(CD1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_vld(din_vld1), .din_rdy(din_rdy1),
    .busy(busy1), .done(done1), .shcp(shcp1), .stcp(stcp1), .ds(ds1), .oe_n(oe_n1));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sb_q0[$];
  logic [31:0] sb_q1[$];

  int          rises[2], first_rise[2], last_rise[2], bad_period[2];
  int          stcp_cnt[2], overlap[2], frames[2], frames_rst[2];
  int          done_cyc[2], prev_done_cyc[2];
  logic [31:0] chain[2];
  logic        prev_shcp[2], last_bit[2], chk_after[2];

  bit busy_win = 1'b0;
  int busy_low = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: models the 595 chain and checks each frame when done pulses.
  always @(negedge clk) begin
    logic s_shcp, s_stcp, s_ds, s_done, s_oe;
    int dw, cd;
    bit msb;
    logic [31:0] exp_w;
    logic [31:0] mask;
    bit empty;
    for (int k = 0; k < 2; k++) begin
      s_shcp = (k == 0) ? shcp0 : shcp1;
      s_stcp = (k == 0) ? stcp0 : stcp1;
      s_ds   = (k == 0) ? ds0 : ds1;
      s_done = (k == 0) ? done0 : done1;
      s_oe   = (k == 0) ? oe_n0 : oe_n1;
      dw     = (k == 0) ? DW0 : DW1;
      cd     = (k == 0) ? CD0 : CD1;
      msb    = (k == 0);
      mask   = (32'h1 << dw) - 32'h1;
      if (!rst_n) begin
        rises[k] = 0; bad_period[k] = 0; stcp_cnt[k] = 0; overlap[k] = 0;
        frames_rst[k] = 0; chain[k] = '0; prev_shcp[k] = 1'b0; chk_after[k] = 1'b0;
      end else begin
        if (chk_after[k]) begin
          checkOutput($sformatf("dut%0d stcp low after done", k), 32'(s_stcp), 32'd0);
          checkOutput($sformatf("dut%0d oe_n low after done", k), 32'(s_oe), 32'd0);
          chk_after[k] = 1'b0;
        end
        if (s_shcp && s_stcp) overlap[k]++;
        if (s_shcp && !prev_shcp[k]) begin
          if (rises[k] == 0) first_rise[k] = cyc;
          else if (cyc - last_rise[k] != 2 * cd) bad_period[k]++;
          last_rise[k] = cyc;
          rises[k]++;
          last_bit[k] = s_ds;
          if (msb) chain[k] = ((chain[k] << 1) | 32'(s_ds)) & mask;
          else     chain[k] = (chain[k] >> 1) | (32'(s_ds) << (dw - 1));
        end
        if (s_stcp) stcp_cnt[k]++;
        if (s_done) begin
          checkOutput($sformatf("dut%0d shcp rises", k), rises[k], dw);
          checkOutput($sformatf("dut%0d shcp period errors", k), bad_period[k], 0);
          checkOutput($sformatf("dut%0d stcp width", k), stcp_cnt[k], cd);
          checkOutput($sformatf("dut%0d frame length", k), cyc - first_rise[k] + cd + 1, dw * 2 * cd + cd);
          checkOutput($sformatf("dut%0d ds held", k), 32'(s_ds), 32'(last_bit[k]));
          checkOutput($sformatf("dut%0d shcp/stcp overlap", k), overlap[k], 0);
          checkOutput($sformatf("dut%0d oe_n at done", k), 32'(s_oe), (frames_rst[k] == 0) ? 32'd1 : 32'd0);
          empty = (k == 0) ? (sb_q0.size() == 0) : (sb_q1.size() == 0);
          if (empty) begin
            checks++;
            $display("[TB] FAIL dut%0d unexpected frame: latched 0x%0h, no word queued", k, chain[k]);
          end else begin
            if (k == 0) exp_w = sb_q0.pop_front();
            else        exp_w = sb_q1.pop_front();
            checkOutput($sformatf("dut%0d latched word", k), chain[k], exp_w);
          end
          prev_done_cyc[k] = done_cyc[k];
          done_cyc[k] = cyc;
          frames[k]++;
          frames_rst[k]++;
          rises[k] = 0; bad_period[k] = 0; stcp_cnt[k] = 0; overlap[k] = 0;
          chk_after[k] = 1'b1;
        end
        prev_shcp[k] = s_shcp;
      end
    end
  end

  always @(negedge clk) if (busy_win && !busy0) busy_low++;

  // Offer a word, wait for acceptance, and queue it as the expected latched value.
  task automatic applyStimulus(input int k, input logic [31:0] w, input bit hold, output int acc_cyc);
    int n;
    logic rdy;
    @(negedge clk);
    if (k == 0) begin din0 = w[DW0-1:0]; din_vld0 = 1'b1; end
    else        begin din1 = w[DW1-1:0]; din_vld1 = 1'b1; end
    n = 0;
    rdy = (k == 0) ? din_rdy0 : din_rdy1;
    while (!rdy && n < 1000) begin
      @(negedge clk);
      n++;
      rdy = (k == 0) ? din_rdy0 : din_rdy1;
    end
    if (!rdy) begin
      checks++;
      $display("[TB] FAIL dut%0d accept timeout: din_rdy stayed 0, expected 1", k);
      acc_cyc = -1;
      din_vld0 = 1'b0; din_vld1 = 1'b0;
    end else begin
      acc_cyc = cyc;
      if (k == 0) sb_q0.push_back(w);
      else        sb_q1.push_back(w);
      @(posedge clk);
      #1;
      if (!hold) begin
        if (k == 0) din_vld0 = 1'b0;
        else        din_vld1 = 1'b0;
      end
    end
  endtask

  task automatic waitFrames(input int k, input int target, input int budget);
    int n = 0;
    while (frames[k] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput($sformatf("dut%0d frames done", k), frames[k], target);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, a2, a3, f, n;

    repeat (3) @(negedge clk);
    checkOutput("reset shcp", 32'(shcp0), 32'd0);
    checkOutput("reset stcp", 32'(stcp0), 32'd0);
    checkOutput("reset ds", 32'(ds0), 32'd0);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset oe_n", 32'(oe_n0), 32'd1);
    checkOutput("reset din_rdy", 32'(din_rdy0), 32'd1);
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset dut1 oe_n", 32'(oe_n1), 32'd1);
    rst_n = 1'b1;

    $display("[TB] single MSB-first frame 0xCFB2");
    applyStimulus(0, 32'hCFB2, 1'b0, a);
    waitFrames(0, 1, 200);

    $display("[TB] 24-bit LSB-first frames, divider 5");
    applyStimulus(1, 32'h123456, 1'b0, a);
    waitFrames(1, 1, 600);
    applyStimulus(1, 32'hA5003C, 1'b0, a);
    waitFrames(1, 2, 600);

    $display("[TB] pending buffer and back-to-back frames");
    f = frames[0];
    applyStimulus(0, 32'h00FF, 1'b0, a);
    busy_win = 1'b1;
    busy_low = 0;
    applyStimulus(0, 32'h002C, 1'b1, a2);
    checkOutput("second word accept delay", a2 - a, 2);
    applyStimulus(0, 32'hA5A5, 1'b0, a3);
    checkOutput("frames before third accept", frames[0], f + 1);
    checkOutput("third accept after done", a3 - done_cyc[0], 2);
    waitFrames(0, f + 2, 200);
    checkOutput("back-to-back spacing 1-2", done_cyc[0] - prev_done_cyc[0], SPACING0);
    waitFrames(0, f + 3, 200);
    busy_win = 1'b0;
    checkOutput("back-to-back spacing 2-3", done_cyc[0] - prev_done_cyc[0], SPACING0);
    checkOutput("busy low cycles in burst", busy_low, 0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, 32'hFFFF, 1'b0, a);
    n = 0;
    while (rises[0] < 8 && n < 200) begin @(posedge clk); n++; end
    checkOutput("reached bit 7", rises[0], 8);
    #3;
    rst_n = 1'b0;
    sb_q0.delete();
    #1;
    checkOutput("async reset shcp", 32'(shcp0), 32'd0);
    checkOutput("async reset stcp", 32'(stcp0), 32'd0);
    checkOutput("async reset ds", 32'(ds0), 32'd0);
    checkOutput("async reset oe_n", 32'(oe_n0), 32'd1);
    checkOutput("async reset busy", 32'(busy0), 32'd0);
    checkOutput("async reset din_rdy", 32'(din_rdy0), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("quiet after reset rises", rises[0], 0);
    checkOutput("quiet after reset busy", 32'(busy0), 32'd0);
    checkOutput("quiet after reset oe_n", 32'(oe_n0), 32'd1);
    f = frames[0];
    applyStimulus(0, 32'h3C96, 1'b0, a);
    waitFrames(0, f + 1, 200);

    $display("[TB] continuous valid with a constant word");
    f = frames[0];
    applyStimulus(0, 32'h5A0F, 1'b1, a);
    applyStimulus(0, 32'h5A0F, 1'b1, a);
    applyStimulus(0, 32'h5A0F, 1'b0, a);
    waitFrames(0, f + 2, 200);
    checkOutput("stream spacing 1-2", done_cyc[0] - prev_done_cyc[0], SPACING0);
    waitFrames(0, f + 3, 200);
    checkOutput("stream spacing 2-3", done_cyc[0] - prev_done_cyc[0], SPACING0);

    repeat (5) @(negedge clk);
    checkOutput("dut0 queue drained", sb_q0.size(), 0);
    checkOutput("dut1 queue drained", sb_q1.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
